// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and frame geometry.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-request / serial-status bundle between a byte producer and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 i_tx_dv;
    logic [DATA_BITS-1:0] i_tx_byte;
    logic                 o_tx_active;
    logic                 o_tx_serial;
    logic                 o_tx_done;

    // Byte producer side.
    modport master (
        output i_tx_dv,
        output i_tx_byte,
        input  o_tx_active,
        input  o_tx_serial,
        input  o_tx_done
    );

    // Transmitter side.
    modport slave (
        input  i_tx_dv,
        input  i_tx_byte,
        output o_tx_active,
        output o_tx_serial,
        output o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, DATA_BITS data bits LSB first, one stop bit.
// Every output is registered; outputs are computed from the next state so that the
// line drops low in the same cycle that o_tx_active rises.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line high, waiting for i_tx_dv
// START   | line low for one bit period
// DATA    | line = byte[bit_idx] for one bit period per bit
// STOP    | line high for one bit period
// CLEANUP | one cycle with done high; active already low
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868   // must be >= 2
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave tx_if
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;

    logic                 bit_end;

    assign bit_end = (clk_cnt_q == CNT_LAST);

    // State and output registers; synchronous reset wins over any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output decode; line level is chosen for the state being entered.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                serial_d  = 1'b1;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (tx_if.i_tx_dv) begin
                    byte_d   = tx_if.i_tx_byte;
                    active_d = 1'b1;
                    serial_d = 1'b0;
                    state_d  = START;
                end
            end

            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    serial_d  = byte_q[0];
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        serial_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = byte_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    done_d    = 1'b1;
                    active_d  = 1'b0;
                    state_d   = CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            CLEANUP: begin
                serial_d = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign tx_if.o_tx_serial = serial_q;
    assign tx_if.o_tx_active = active_q;
    assign tx_if.o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (4 clocks/bit) for frame content and
// corner cases, and a default-rate instance (868 clocks/bit) for bit timing.
module tb_uart_tx;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    uart_tx_if if4 ();
    uart_tx_if if868 ();

    uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .tx_if (if4)
    );

    uart_tx dut868 (
        .clk   (clk),
        .reset (reset),
        .tx_if (if868)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle4(input string tag);
        chk({tag, ".serial"}, {31'd0, if4.o_tx_serial}, 32'd1);
        chk({tag, ".active"}, {31'd0, if4.o_tx_active}, 32'd0);
        chk({tag, ".done"},   {31'd0, if4.o_tx_done},   32'd0);
    endtask

    // Called in the first cycle after the accepting edge; checks all 40 cycles of the
    // frame, the done pulse, and the following CLEANUP cycle.
    task automatic frame_check4(input string tag, input logic [7:0] data, input bit inject_busy);
        logic [9:0] bits;
        bits = {1'b1, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("%s.bit%0d.c%0d.serial", tag, b, c), {31'd0, if4.o_tx_serial}, {31'd0, bits[b]});
                chk($sformatf("%s.bit%0d.c%0d.active", tag, b, c), {31'd0, if4.o_tx_active}, 32'd1);
                chk($sformatf("%s.bit%0d.c%0d.done", tag, b, c),   {31'd0, if4.o_tx_done},   32'd0);
                if (inject_busy && b == 3 && c == 1) begin
                    if4.i_tx_dv   = 1'b1;
                    if4.i_tx_byte = 8'hFF;
                end
                if (inject_busy && b == 3 && c == 2) begin
                    if4.i_tx_dv = 1'b0;
                end
                tick();
            end
        end
        chk({tag, ".done_pulse"},   {31'd0, if4.o_tx_done},   32'd1);
        chk({tag, ".active_fall"},  {31'd0, if4.o_tx_active}, 32'd0);
        chk({tag, ".serial_stop"},  {31'd0, if4.o_tx_serial}, 32'd1);
        tick();
        chk({tag, ".done_clear"},   {31'd0, if4.o_tx_done},   32'd0);
        chk({tag, ".active_clean"}, {31'd0, if4.o_tx_active}, 32'd0);
        chk({tag, ".serial_clean"}, {31'd0, if4.o_tx_serial}, 32'd1);
    endtask

    initial begin
        int       done_seen;
        int       active_seen;
        int       total;
        int       run_len;
        logic     level;
        int       runs[$];
        int       exp_runs[6];
        int       got;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        if4.i_tx_dv     = 1'b0;
        if4.i_tx_byte   = 8'h00;
        if868.i_tx_dv   = 1'b0;
        if868.i_tx_byte = 8'h00;

        // Reset held three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle4($sformatf("reset.c%0d", i));
        end
        reset = 1'b0;
        tick();
        chk_idle4("post_reset");
        tick();
        chk_idle4("post_reset2");

        // Single frame 0xA5; byte input scrambled after acceptance.
        if4.i_tx_dv   = 1'b1;
        if4.i_tx_byte = 8'hA5;
        tick();
        if4.i_tx_dv   = 1'b0;
        if4.i_tx_byte = 8'h00;
        frame_check4("a5", 8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle4($sformatf("a5.idle%0d", i));
        end

        // Request for 0xFF during the 0x3C data phase must be dropped.
        if4.i_tx_dv   = 1'b1;
        if4.i_tx_byte = 8'h3C;
        tick();
        if4.i_tx_dv   = 1'b0;
        frame_check4("busy3c", 8'h3C, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_idle4($sformatf("busy3c.idle%0d", i));
        end

        // Back-to-back with dv held high: 0x00 then 0xFF.
        if4.i_tx_dv   = 1'b1;
        if4.i_tx_byte = 8'h00;
        tick();
        if4.i_tx_byte = 8'hFF;
        frame_check4("b2b0", 8'h00, 1'b0);
        tick();
        if4.i_tx_dv = 1'b0;
        frame_check4("b2b1", 8'hFF, 1'b0);
        tick();
        chk_idle4("b2b.idle");

        // Reset during data bit 3 of 0x55.
        if4.i_tx_dv   = 1'b1;
        if4.i_tx_byte = 8'h55;
        tick();
        if4.i_tx_dv = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("rst_mid.pre_active", {31'd0, if4.o_tx_active}, 32'd1);
        chk("rst_mid.pre_serial", {31'd0, if4.o_tx_serial}, 32'd0);
        reset = 1'b1;
        tick();
        chk_idle4("rst_mid.abort");
        reset = 1'b0;
        done_seen   = 0;
        active_seen = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (if4.o_tx_done === 1'b1)   done_seen++;
            if (if4.o_tx_active === 1'b1) active_seen++;
        end
        chk("rst_mid.no_done",   done_seen,   32'd0);
        chk("rst_mid.no_active", active_seen, 32'd0);

        // Reset and request together: reset wins.
        reset       = 1'b1;
        if4.i_tx_dv = 1'b1;
        if4.i_tx_byte = 8'h81;
        tick();
        chk_idle4("rst_dv.same");
        reset       = 1'b0;
        if4.i_tx_dv = 1'b0;
        tick();
        chk_idle4("rst_dv.after");

        // Frame after the aborted one.
        if4.i_tx_dv   = 1'b1;
        if4.i_tx_byte = 8'h81;
        tick();
        if4.i_tx_dv = 1'b0;
        frame_check4("post81", 8'h81, 1'b0);

        // Default rate, 0x41: line runs are start(0), b0(1), b1..b5(0), b6(1), b7(0), stop(1).
        if868.i_tx_dv   = 1'b1;
        if868.i_tx_byte = 8'h41;
        tick();
        if868.i_tx_dv = 1'b0;
        chk("d868.start_level", {31'd0, if868.o_tx_serial}, 32'd0);
        total   = 0;
        run_len = 0;
        level   = if868.o_tx_serial;
        while (if868.o_tx_active === 1'b1 && total < 10000) begin
            if (if868.o_tx_serial !== level) begin
                runs.push_back(run_len);
                level   = if868.o_tx_serial;
                run_len = 0;
            end
            run_len++;
            total++;
            tick();
        end
        runs.push_back(run_len);
        chk("d868.timeout", {31'd0, total < 10000}, 32'd1);
        chk("d868.total", total, 32'd8680);
        chk("d868.done", {31'd0, if868.o_tx_done}, 32'd1);
        chk("d868.runs", runs.size(), 32'd6);
        exp_runs = '{868, 868, 4340, 868, 868, 868};
        for (int i = 0; i < 6; i++) begin
            got = (i < runs.size()) ? runs[i] : 0;
            chk($sformatf("d868.run%0d", i), got, exp_runs[i]);
        end
        tick();
        chk("d868.done_clear", {31'd0, if868.o_tx_done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
